// File: rtl/lcd_pixel_fetch.sv
// lcd_pixel_fetch
// Sits behind the LCD RGB timing generator. Pops RGB565 pixels from the
// SDRAM read FIFO during active video and drives the panel pins. Sync and
// data are re-aligned through a matched 2-stage pipeline. A one-cycle frame
// restart request goes to the SDRAM read controller at every vertical sync.
// When the FIFO cannot supply a pixel, a fixed colour is substituted and
// the event is counted.
module lcd_pixel_fetch #(
   parameter int          H_ACTIVE = 480,
   parameter int          V_ACTIVE = 272,
   parameter int          PREFILL  = 64,
   parameter logic        VS_POL   = 1'b0,
   parameter logic [15:0] UF_COLOR = 16'hF800
) (
   input  logic        rgb_clk,
   input  logic        rst_n,
   input  logic        in_hs,
   input  logic        in_vs,
   input  logic        in_de,
   output logic        fifo_rd_en,
   input  logic [15:0] fifo_rd_data,
   input  logic        fifo_empty,
   input  logic [9:0]  fifo_usedw,
   output logic        frame_req,
   output logic        lcd_hs,
   output logic        lcd_vs,
   output logic        lcd_de,
   output logic [15:0] lcd_rgb,
   output logic [15:0] underflow_cnt
);

   localparam logic [16:0] PIX_LAST    = 17'(H_ACTIVE * V_ACTIVE - 1);
   localparam logic [9:0]  PREFILL_LVL = 10'(PREFILL);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_FILL   = 2'd1,
      ST_STREAM = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   // Per-pixel tag that travels alongside sync through the pipeline
   typedef enum logic [1:0] {
      TAG_BLANK = 2'd0,
      TAG_GOOD  = 2'd1,
      TAG_UF    = 2'd2
   } tag_t;

   state_t      state_r, state_s;
   logic [16:0] pix_cnt_r, pix_cnt_s;
   logic        vs_d_r;
   logic        vs_start_s;
   logic        counting_s;
   logic        last_pix_s;
   tag_t        tag_s, tag_1_r;
   logic        hs_1_r, vs_1_r, de_1_r;
   logic [15:0] rgb_s;

   // A vsync edge is the first cycle in_vs sits at its active level
   assign vs_start_s = (in_vs == VS_POL) && (vs_d_r != VS_POL);
   assign last_pix_s = (pix_cnt_r == PIX_LAST);

   // State, pixel counter and vsync history registers
   always_ff @(posedge rgb_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r   <= ST_IDLE;
         pix_cnt_r <= 17'd0;
         vs_d_r    <= VS_POL;
      end else begin
         state_r   <= state_s;
         pix_cnt_r <= pix_cnt_s;
         vs_d_r    <= in_vs;
      end
   end

   // Next state, FIFO pop and pixel tag; vsync overrides everything
   always_comb begin
      state_s    = state_r;
      pix_cnt_s  = pix_cnt_r;
      fifo_rd_en = 1'b0;
      tag_s      = TAG_BLANK;
      counting_s = 1'b0;
      case (state_r)
         ST_FILL: begin
            counting_s = in_de;
            if (in_de) tag_s = TAG_UF;
            else       tag_s = TAG_BLANK;
            if (fifo_usedw >= PREFILL_LVL) state_s = ST_STREAM;
            else                           state_s = ST_FILL;
         end
         ST_STREAM: begin
            counting_s = in_de;
            if (in_de && !fifo_empty && !vs_start_s) begin
               fifo_rd_en = 1'b1;
               tag_s      = TAG_GOOD;
            end else if (in_de) begin
               tag_s = TAG_UF;
            end else begin
               tag_s = TAG_BLANK;
            end
         end
         ST_IDLE, ST_DONE: begin
            state_s = state_r;
            tag_s   = TAG_BLANK;
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
      if (vs_start_s) begin
         state_s   = ST_FILL;
         pix_cnt_s = 17'd0;
      end else if (counting_s && last_pix_s) begin
         state_s   = ST_DONE;
         pix_cnt_s = pix_cnt_r + 17'd1;
      end else if (counting_s) begin
         pix_cnt_s = pix_cnt_r + 17'd1;
      end else begin
         pix_cnt_s = pix_cnt_r;
      end
   end

   // Stage 1: sync, tag and frame restart request (FIFO data arrives now)
   always_ff @(posedge rgb_clk or negedge rst_n) begin
      if (!rst_n) begin
         hs_1_r    <= 1'b0;
         vs_1_r    <= 1'b0;
         de_1_r    <= 1'b0;
         tag_1_r   <= TAG_BLANK;
         frame_req <= 1'b0;
      end else begin
         hs_1_r    <= in_hs;
         vs_1_r    <= in_vs;
         de_1_r    <= in_de;
         tag_1_r   <= tag_s;
         frame_req <= vs_start_s;
      end
   end

   // Pixel value selected by the tag; blank pixels are black
   always_comb begin
      rgb_s = 16'h0000;
      case (tag_1_r)
         TAG_GOOD: rgb_s = fifo_rd_data;
         TAG_UF:   rgb_s = UF_COLOR;
         default:  rgb_s = 16'h0000;
      endcase
   end

   // Stage 2: panel pins, kept in step with the pixel data
   always_ff @(posedge rgb_clk or negedge rst_n) begin
      if (!rst_n) begin
         lcd_hs  <= 1'b0;
         lcd_vs  <= 1'b0;
         lcd_de  <= 1'b0;
         lcd_rgb <= 16'h0000;
      end else begin
         lcd_hs  <= hs_1_r;
         lcd_vs  <= vs_1_r;
         lcd_de  <= de_1_r;
         lcd_rgb <= rgb_s;
      end
   end

   // Saturating count of substituted pixels, cleared only by reset
   always_ff @(posedge rgb_clk or negedge rst_n) begin
      if (!rst_n) begin
         underflow_cnt <= 16'h0000;
      end else if ((tag_1_r == TAG_UF) && (underflow_cnt != 16'hFFFF)) begin
         underflow_cnt <= underflow_cnt + 16'h0001;
      end else begin
         underflow_cnt <= underflow_cnt;
      end
   end

endmodule

// File: tb/tb_lcd_pixel_fetch.sv
// Self-checking bench for lcd_pixel_fetch with a small frame geometry.
module tb_lcd_pixel_fetch;

   localparam int          H   = 8;
   localparam int          V   = 3;
   localparam int          PRE = 16;
   localparam logic [15:0] UF  = 16'hF800;
   localparam int          LOG = 2048;

   logic        rgb_clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_hs = 1'b1, in_vs = 1'b1, in_de = 1'b0;
   logic        fifo_rd_en;
   logic [15:0] fifo_rd_data = 16'h0000;
   logic        fifo_empty = 1'b0;
   logic [9:0]  fifo_usedw = 10'd0;
   logic        frame_req, lcd_hs, lcd_vs, lcd_de;
   logic [15:0] lcd_rgb, underflow_cnt;

   int vectors = 0;
   int miscompares = 0;

   // FIFO contents and read pointer (SDRAM frame restarts on frame_req)
   logic [15:0] mem [0:255];
   logic [7:0]  rd_ptr = 8'd0;

   // Per-cycle logs: inputs at step j, outputs sampled at step j
   logic        i_hs_l [0:LOG-1], i_vs_l [0:LOG-1], i_de_l [0:LOG-1], i_em_l [0:LOG-1];
   logic        rd_en_l [0:LOG-1], o_req_l [0:LOG-1];
   logic        o_hs_l [0:LOG-1], o_vs_l [0:LOG-1], o_de_l [0:LOG-1];
   logic [15:0] o_rgb_l [0:LOG-1];
   int          cyc = 0;

   // Reference model results for the most recent frame
   logic [15:0] exp_q [$];
   int          pops_exp, uf_exp, fr_start, fr_stop, vs_cyc, ex_start;

   lcd_pixel_fetch #(
      .H_ACTIVE(H), .V_ACTIVE(V), .PREFILL(PRE), .VS_POL(1'b0), .UF_COLOR(UF)
   ) dut (
      .rgb_clk(rgb_clk), .rst_n(rst_n),
      .in_hs(in_hs), .in_vs(in_vs), .in_de(in_de),
      .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data),
      .fifo_empty(fifo_empty), .fifo_usedw(fifo_usedw),
      .frame_req(frame_req),
      .lcd_hs(lcd_hs), .lcd_vs(lcd_vs), .lcd_de(lcd_de),
      .lcd_rgb(lcd_rgb), .underflow_cnt(underflow_cnt)
   );

   always #5 rgb_clk = ~rgb_clk;

   // Non-show-ahead FIFO: data appears the cycle after a pop
   always @(posedge rgb_clk) begin
      if (frame_req) rd_ptr <= 8'd0;
      else if (fifo_rd_en) begin
         fifo_rd_data <= mem[rd_ptr];
         rd_ptr       <= rd_ptr + 8'd1;
      end
   end

   task automatic step(input logic hs, input logic vs, input logic de,
                       input logic em, input logic [9:0] uw);
      @(negedge rgb_clk);
      o_hs_l[cyc] = lcd_hs;  o_vs_l[cyc] = lcd_vs;  o_de_l[cyc] = lcd_de;
      o_rgb_l[cyc] = lcd_rgb; o_req_l[cyc] = frame_req;
      in_hs = hs; in_vs = vs; in_de = de; fifo_empty = em; fifo_usedw = uw;
      i_hs_l[cyc] = hs; i_vs_l[cyc] = vs; i_de_l[cyc] = de; i_em_l[cyc] = em;
      #1;
      rd_en_l[cyc] = fifo_rd_en;
      cyc++;
   endtask

   // One frame of stimulus plus the expected pixel sequence from plain rules:
   // first low_fill pixels and the empty burst are UF, the rest take FIFO
   // words in order, extra pixels past the frame are black.
   task automatic run_frame(input int low_fill, input int ef_pos, input int ef_len, input int extra);
      logic [9:0] uw;
      int k, w;
      logic e;
      exp_q.delete();
      w  = 0;
      k  = 0;
      uw = (low_fill > 0) ? 10'd10 : 10'd200;
      fr_start = cyc;
      step(1'b1, 1'b1, 1'b0, 1'b0, uw);
      vs_cyc = cyc;
      step(1'b1, 1'b0, 1'b0, 1'b0, uw);
      step(1'b1, 1'b0, 1'b0, 1'b0, uw);
      step(1'b1, 1'b1, 1'b0, 1'b0, uw);
      for (int ln = 0; ln < V; ln++) begin
         step(1'b0, 1'b1, 1'b0, 1'b0, uw);
         repeat ($urandom_range(1, 4)) step(1'b1, 1'b1, 1'b0, 1'b0, uw);
         for (int p = 0; p < H; p++) begin
            if (low_fill > 0 && k == low_fill) begin
               uw = 10'd100;
               step(1'b1, 1'b1, 1'b0, 1'b0, uw);
            end
            e = (k >= ef_pos) && (k < ef_pos + ef_len);
            step(1'b1, 1'b1, 1'b1, e, uw);
            if (k < low_fill || e) begin
               exp_q.push_back(UF);
               uf_exp++;
            end else begin
               exp_q.push_back(mem[w]);
               w++;
            end
            k++;
         end
      end
      repeat (2) step(1'b1, 1'b1, 1'b0, 1'b0, uw);
      ex_start = cyc;
      for (int x = 0; x < extra; x++) begin
         step(1'b1, 1'b1, 1'b1, 1'b0, uw);
         exp_q.push_back(16'h0000);
      end
      repeat (3) step(1'b1, 1'b1, 1'b0, 1'b0, uw);
      pops_exp = w;
      fr_stop  = cyc;
   endtask

   task automatic test_reset();
      int s;
      repeat (3) step(1'b1, 1'b1, 1'b0, 1'b0, 10'd0);
      vectors++;
      if ({lcd_hs, lcd_vs, lcd_de, frame_req, fifo_rd_en} !== 5'b00000) begin
         miscompares++;
         $display("FAIL reset_ctrl got=%b want=00000", {lcd_hs, lcd_vs, lcd_de, frame_req, fifo_rd_en});
      end
      vectors++;
      if ({lcd_rgb, underflow_cnt} !== 32'h0) begin
         miscompares++;
         $display("FAIL reset_data got=%h want=00000000", {lcd_rgb, underflow_cnt});
      end
      rst_n  = 1'b1;
      uf_exp = 0;
      s = cyc;
      repeat (6) step(1'b1, 1'b1, 1'b1, 1'b0, 10'd200);
      repeat (3) step(1'b1, 1'b1, 1'b0, 1'b0, 10'd200);
      for (int j = s; j < cyc - 2; j++) begin
         vectors++;
         if ({rd_en_l[j], o_req_l[j + 1], o_rgb_l[j + 2]} !== 18'h0) begin
            miscompares++;
            $display("FAIL idle_quiet cyc=%0d got=%b/%b/%h want=0/0/0000", j, rd_en_l[j], o_req_l[j + 1], o_rgb_l[j + 2]);
         end
      end
   endtask

   task automatic test_full_frame();
      int n, pops;
      run_frame(0, -1, 0, 4);
      n = 0;
      pops = 0;
      for (int j = fr_start; j < fr_stop - 2; j++) begin
         logic [15:0] want;
         if (i_de_l[j]) begin want = exp_q[n]; n++; end
         else want = 16'h0000;
         vectors++;
         if (o_rgb_l[j + 2] !== want) begin
            miscompares++;
            $display("FAIL full_rgb cyc=%0d got=%h want=%h", j, o_rgb_l[j + 2], want);
         end
         vectors++;
         if ({o_hs_l[j + 2], o_vs_l[j + 2], o_de_l[j + 2]} !== {i_hs_l[j], i_vs_l[j], i_de_l[j]}) begin
            miscompares++;
            $display("FAIL full_sync cyc=%0d got=%b%b%b want=%b%b%b", j, o_hs_l[j + 2], o_vs_l[j + 2],
                     o_de_l[j + 2], i_hs_l[j], i_vs_l[j], i_de_l[j]);
         end
         vectors++;
         if (o_req_l[j + 1] !== (j == vs_cyc)) begin
            miscompares++;
            $display("FAIL full_req cyc=%0d got=%b want=%b", j, o_req_l[j + 1], (j == vs_cyc));
         end
      end
      for (int j = fr_start; j < fr_stop; j++) pops += int'(rd_en_l[j]);
      for (int j = ex_start; j < ex_start + 4; j++) begin
         vectors++;
         if (rd_en_l[j] !== 1'b0) begin
            miscompares++;
            $display("FAIL done_pop cyc=%0d got=%b want=0", j, rd_en_l[j]);
         end
      end
      vectors++;
      if (pops !== pops_exp) begin
         miscompares++;
         $display("FAIL full_pops got=%0d want=%0d", pops, pops_exp);
      end
      vectors++;
      if (underflow_cnt !== 16'(uf_exp)) begin
         miscompares++;
         $display("FAIL full_ufcnt got=%0d want=%0d", underflow_cnt, uf_exp);
      end
   endtask

   task automatic test_prefill_underflow();
      int n;
      run_frame(5, -1, 0, 0);
      n = 0;
      for (int j = fr_start; j < fr_stop - 2; j++) begin
         logic [15:0] want;
         if (i_de_l[j]) begin want = exp_q[n]; n++; end
         else want = 16'h0000;
         vectors++;
         if (o_rgb_l[j + 2] !== want) begin
            miscompares++;
            $display("FAIL prefill_rgb cyc=%0d got=%h want=%h", j, o_rgb_l[j + 2], want);
         end
      end
      vectors++;
      if (underflow_cnt !== 16'(uf_exp)) begin
         miscompares++;
         $display("FAIL prefill_ufcnt got=%0d want=%0d", underflow_cnt, uf_exp);
      end
   endtask

   task automatic test_empty_burst();
      int n;
      run_frame(0, int'($urandom_range(H, 2 * H - 4)), 3, 0);
      n = 0;
      for (int j = fr_start; j < fr_stop - 2; j++) begin
         logic [15:0] want;
         if (i_de_l[j]) begin want = exp_q[n]; n++; end
         else want = 16'h0000;
         vectors++;
         if (o_rgb_l[j + 2] !== want) begin
            miscompares++;
            $display("FAIL empty_rgb cyc=%0d got=%h want=%h", j, o_rgb_l[j + 2], want);
         end
         if (i_em_l[j]) begin
            vectors++;
            if (rd_en_l[j] !== 1'b0) begin
               miscompares++;
               $display("FAIL empty_pop cyc=%0d got=%b want=0", j, rd_en_l[j]);
            end
         end
      end
      vectors++;
      if (underflow_cnt !== 16'(uf_exp)) begin
         miscompares++;
         $display("FAIL empty_ufcnt got=%0d want=%0d", underflow_cnt, uf_exp);
      end
   endtask

   task automatic test_vs_during_stream();
      int a;
      step(1'b1, 1'b1, 1'b0, 1'b0, 10'd200);
      step(1'b1, 1'b0, 1'b0, 1'b0, 10'd200);
      repeat (3) step(1'b1, 1'b1, 1'b0, 1'b0, 10'd200);
      repeat (5) step(1'b1, 1'b1, 1'b1, 1'b0, 10'd200);
      a = cyc;
      step(1'b1, 1'b0, 1'b1, 1'b0, 10'd200);
      step(1'b1, 1'b0, 1'b1, 1'b0, 10'd200);
      step(1'b1, 1'b1, 1'b1, 1'b0, 10'd200);
      repeat (3) step(1'b1, 1'b1, 1'b0, 1'b0, 10'd200);
      uf_exp += 2;
      vectors++;
      if ({rd_en_l[a], rd_en_l[a + 1], rd_en_l[a + 2]} !== 3'b001) begin
         miscompares++;
         $display("FAIL vsde_pops got=%b%b%b want=001", rd_en_l[a], rd_en_l[a + 1], rd_en_l[a + 2]);
      end
      vectors++;
      if (o_req_l[a + 1] !== 1'b1) begin
         miscompares++;
         $display("FAIL vsde_req got=%b want=1", o_req_l[a + 1]);
      end
      vectors++;
      if ({o_rgb_l[a + 2], o_rgb_l[a + 3], o_rgb_l[a + 4]} !== {UF, UF, mem[0]}) begin
         miscompares++;
         $display("FAIL vsde_rgb got=%h %h %h want=%h %h %h", o_rgb_l[a + 2], o_rgb_l[a + 3],
                  o_rgb_l[a + 4], UF, UF, mem[0]);
      end
      vectors++;
      if (underflow_cnt !== 16'(uf_exp)) begin
         miscompares++;
         $display("FAIL vsde_ufcnt got=%0d want=%0d", underflow_cnt, uf_exp);
      end
   endtask

   task automatic test_reset_midline();
      int s;
      step(1'b1, 1'b1, 1'b0, 1'b0, 10'd200);
      step(1'b1, 1'b0, 1'b0, 1'b0, 10'd200);
      repeat (3) step(1'b1, 1'b1, 1'b0, 1'b0, 10'd200);
      repeat (4) step(1'b1, 1'b1, 1'b1, 1'b0, 10'd200);
      #1 rst_n = 1'b0;
      #1;
      vectors++;
      if ({lcd_hs, lcd_vs, lcd_de, frame_req, fifo_rd_en} !== 5'b00000) begin
         miscompares++;
         $display("FAIL midrst_ctrl got=%b want=00000", {lcd_hs, lcd_vs, lcd_de, frame_req, fifo_rd_en});
      end
      vectors++;
      if ({lcd_rgb, underflow_cnt} !== 32'h0) begin
         miscompares++;
         $display("FAIL midrst_data got=%h want=00000000", {lcd_rgb, underflow_cnt});
      end
      uf_exp = 0;
      repeat (2) step(1'b1, 1'b0, 1'b0, 1'b0, 10'd200);
      #1 rst_n = 1'b1;
      s = cyc;
      repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0, 10'd200);
      repeat (2) step(1'b1, 1'b1, 1'b0, 1'b0, 10'd200);
      repeat (6) step(1'b1, 1'b1, 1'b1, 1'b0, 10'd200);
      repeat (3) step(1'b1, 1'b1, 1'b0, 1'b0, 10'd200);
      for (int j = s; j < cyc - 2; j++) begin
         vectors++;
         if ({rd_en_l[j], o_req_l[j + 1], o_rgb_l[j + 2]} !== 18'h0) begin
            miscompares++;
            $display("FAIL postrst_quiet cyc=%0d got=%b/%b/%h want=0/0/0000", j, rd_en_l[j], o_req_l[j + 1], o_rgb_l[j + 2]);
         end
      end
      vectors++;
      if (underflow_cnt !== 16'h0000) begin
         miscompares++;
         $display("FAIL postrst_ufcnt got=%0d want=0", underflow_cnt);
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
      test_reset();
      test_full_frame();
      test_prefill_underflow();
      test_empty_burst();
      test_vs_during_stream();
      test_reset_midline();
      test_full_frame();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/lcd_pixel_fetch.md
# lcd_pixel_fetch

Downstream consumer of the LCD RGB timing generator. Takes its sync/enable outputs, pops RGB565 pixels from the SDRAM read FIFO during active video, and drives the panel pins with sync and data re-aligned. Issues a one-cycle frame restart request to the SDRAM read controller at every vertical sync. Substitutes a fixed colour and counts the event whenever the FIFO cannot supply a pixel.

## Interface
Parameters:
- H_ACTIVE, 480: active pixels per line.
- V_ACTIVE, 272: active lines per frame.
- PREFILL, 64: FIFO words required before streaming starts.
- VS_POL, 1'b0: active level of in_vs (1'b0 = active low).
- UF_COLOR, 16'hF800: RGB565 value output on underflow.

Ports:
- rgb_clk, in, 1: pixel clock; the block's only clock.
- rst_n, in, 1: asynchronous active-low reset.
- in_hs, in, 1: horizontal sync from the timing generator.
- in_vs, in, 1: vertical sync from the timing generator.
- in_de, in, 1: data enable from the timing generator.
- fifo_rd_en, out, 1: FIFO pop; combinational.
- fifo_rd_data, in, 16: FIFO read data; normal (non-show-ahead) mode, valid the cycle after fifo_rd_en.
- fifo_empty, in, 1: FIFO empty flag.
- fifo_usedw, in, 10: FIFO fill level.
- frame_req, out, 1: one-cycle pulse that restarts the SDRAM frame read.
- lcd_hs, out, 1: panel horizontal sync.
- lcd_vs, out, 1: panel vertical sync.
- lcd_de, out, 1: panel data enable.
- lcd_rgb, out, 16: panel pixel data.
- underflow_cnt, out, 16: count of substituted pixels; saturating.

## Operation
- VS edge detection:
  - vs_d is a register of in_vs; it resets to VS_POL so that no edge is detected out of reset.
  - vs_start = (in_vs == VS_POL) && (vs_d != VS_POL).
- States: IDLE, FILL, STREAM, DONE. Reset enters IDLE.
- vs_start takes priority from any state:
  - frame_req = 1 for that single cycle.
  - pix_cnt (17 bit) is cleared.
  - Next state is FILL.
- FILL:
  - Transitions to STREAM when fifo_usedw >= PREFILL.
  - No pops occur in FILL.
- STREAM, active pixel (in_de = 1):
  - fifo_rd_en = in_de && !fifo_empty && !vs_start.
  - If popped, the pixel is marked good; otherwise it is marked underflow.
- FILL, active pixel (in_de = 1): the pixel is marked underflow.
- pix_cnt:
  - Increments on every in_de cycle in FILL or STREAM, whether the pixel is popped or substituted.
  - When it reaches H_ACTIVE*V_ACTIVE, the state goes to DONE.
- DONE:
  - No pops occur.
  - Any in_de pixels output 16'h0000 and are not counted as underflow.
- IDLE: same output behaviour as DONE; the state is left only on vs_start.
- Underflow:
  - Each underflow-marked pixel outputs UF_COLOR.
  - Each one increments underflow_cnt, which saturates at 16'hFFFF.
  - The count is cleared only by reset.
- A short frame (vs_start arrives before pix_cnt reaches its terminal value) aborts the current frame and restarts cleanly.
- A mid-frame underflow is not re-synchronised within the frame; the next vs_start realigns the image.

## Timing
- Pipeline:
  - Cycle t: in_de and fifo_rd_en.
  - Cycle t+1: fifo_rd_data is valid and is registered.
  - Cycle t+2: lcd_rgb is valid.
- lcd_hs, lcd_vs and lcd_de are in_hs, in_vs and in_de delayed by exactly 2 registers, so data and sync stay aligned.
- The good/underflow/blank tag of each pixel travels with the 2-stage pipeline.
- lcd_rgb is 16'h0000 whenever the delayed lcd_de is 0.
- frame_req is registered and is high in the cycle after the vs_start cycle.
- FILL to STREAM takes effect the cycle after fifo_usedw >= PREFILL is sampled.
- Reset (async, any time, including mid-frame):
  - lcd_hs, lcd_vs, lcd_de, lcd_rgb, frame_req and underflow_cnt = 0.
  - All pipeline stages clear; state is IDLE.
  - fifo_rd_en is 0 during reset and in IDLE.

## Test plan
- Reset then full frame, FIFO kept at 200 words holding a ramp: frame_req pulses once, and lcd_rgb reproduces the ramp 2 cycles after in_de. lcd_de, lcd_hs and lcd_vs equal the inputs delayed by 2. underflow_cnt = 0.
- FIFO held at usedw = 10 through vs and 5 active pixels, then raised to 100: the first 5 pixels are 16'hF800, underflow_cnt = 5, and the 6th pixel is the first FIFO word.
- fifo_empty forced high for 3 in_de cycles mid-line in STREAM: exactly 3 pixels of UF_COLOR, no pops in those cycles, and surrounding pixels are contiguous FIFO data.
- After 480*272 pops, de is driven for 4 extra pixels: no pops, lcd_rgb = 0, underflow_cnt unchanged.
- vs_start coinciding with in_de in STREAM: no pop in that cycle, frame_req pulses, state is FILL.
- rst_n asserted mid-line with pixels in the pipeline: all outputs 0 immediately. After release, no frame_req until the next vs_start, and no spurious edge from the vs_d reset value.
